fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch stage of the MIPS-lite core, directly upstream of the main control decoder. Holds the program counter and fetches one instruction per step from instruction memory over a req/ack handshake. Presents the latched instruction, including its opcode and funct fields, to control/datapath for one execute window. Selects the next PC from sequential, branch-taken (beq/bltzal) and register-jump (jmnor) inputs.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  instruction data valid on imem_rdata
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- opcode  out  6  instr[31:26], feeds control decoder
- funct  out  6  instr[5:0]
- instr_valid  out  1  high while the instruction is in its execute window
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4, used as link value by bltzal
- stall  in  1  datapath not done; hold execute window
- branch_taken  in  1  branch resolved taken (beq equal / bltzal negative)
- jreg_taken  in  1  register jump taken (jmnor)
- jreg_target  in  32  register jump target
- retired  out  32  count of completed instructions

## Operation
- States: RST, FETCH, EXEC.
- RST: lasts exactly one cycle after reset deasserts. imem_req=0, instr_valid=0. Goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_ack=1: latch imem_rdata into instr, go to EXEC.
  - Otherwise stay in FETCH.
- EXEC:
  - instr_valid=1, imem_req=0.
  - stall=1: stay in EXEC. instr, pc and retired are held.
  - stall=0: load next_pc, increment retired, go to FETCH.
- next_pc priority, sampled in the EXEC cycle where stall=0:
  - jreg_taken: {jreg_target[31:2], 2'b00}. The low bits are silently cleared.
  - else branch_taken: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - else pc_plus4.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000.
  - retired wraps from 0xFFFF_FFFF to 0.
- Ignored inputs:
  - branch_taken, jreg_taken and jreg_target are ignored outside EXEC.
  - imem_ack is ignored outside FETCH.
- opcode, funct and pc_plus4 are continuous functions of instr and pc.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, state=RST. Hence opcode=0, funct=0, pc_plus4=RESET_PC+4.
- Reset is sampled at the clock edge and overrides everything, including a pending ack or a stalled EXEC. An ack arriving in the cycle reset is high, or in the following RST cycle, is discarded.
- imem_addr is registered and stays stable for the whole duration imem_req is high.
- An ack in the first FETCH cycle gives the minimum instruction period of 2 cycles. Each ack wait cycle and each stall cycle adds 1.
- instr_valid rises in the cycle after the accepted ack. It falls in the cycle after the EXEC cycle with stall=0.
- pc updates on the same edge that leaves EXEC. imem_req rises on that same edge.

## Test plan
- Reset and first fetch: reset for 2 cycles, memory acks immediately.
  - imem_req first rises 1 cycle after reset falls, with imem_addr=0x0040_0000.
  - Acking rdata=0x8C08_0004 gives instr_valid next cycle with opcode=6'b100011.
- Sequential run with wait states: 3 instructions, ack delayed 2 cycles each, no stalls.
  - Addresses 0x0040_0000, _0004, _0008.
  - retired=3.
  - Period is 4 cycles per instruction.
- Branch: at pc=0x0040_0008, instr=0x1109_FFFF, branch_taken=1.
  - next pc=0x0040_0008, a self-loop.
- Branch forward: imm=0x0003 at pc=0x0040_0010.
  - next pc=0x0040_0020.
- Register jump: jreg_taken=1 and branch_taken=1 together, jreg_target=0x0040_0103.
  - next pc=0x0040_0100: jump wins and the low bits are cleared.
- Stall and wrap-around:
  - With stall=1 for 5 EXEC cycles, instr, pc and retired hold and imem_req stays 0.
  - With pc forced to 0xFFFF_FFFC (RESET_PC override) and a sequential step, next pc=0x0000_0000.
- Mid-operation reset: reset during FETCH while ack is pending, then ack asserted in the RST cycle.
  - The ack is ignored.
  - pc=RESET_PC, retired=0.
  - A fresh request is issued the following cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, fetches one word per step over a
// req/ack handshake and holds it for one execute window.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jreg_taken,
  input  logic [31:0] jreg_target,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {RST, FETCH, EXEC} state_t;

  state_t      state;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        unused_jt;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  // jump targets are forced word-aligned, so the low two bits never matter
  assign unused_jt = &{1'b0, jreg_target[1:0]};

  always_comb begin
    next_pc = pc_plus4;
    if (jreg_taken)        next_pc = {jreg_target[31:2], 2'b00};
    else if (branch_taken) next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RST;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        RST: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= RST;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
